// File: rtl/frog_pkg.sv
// Shared types for the frog collision judge: coordinate width, box struct,
// scan FSM states and score width.
package frog_pkg;

  localparam int COORD_W = 12;
  localparam int SCORE_W = 8;

  typedef struct packed {
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] x2;
    logic [COORD_W-1:0] y1;
    logic [COORD_W-1:0] y2;
  } box_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

endpackage

// File: rtl/frog_collide_box_overlap.sv
// Strict axis-aligned overlap of two boxes; boxes whose edges only touch
// do not overlap.
import frog_pkg::*;

module box_overlap (
  input  box_t a,
  input  box_t b,
  output logic hit
);

  // Unsigned compares on all four edges
  always_comb begin
    hit = (a.x1 < b.x2) && (b.x1 < a.x2) && (a.y1 < b.y2) && (b.y1 < a.y2);
  end

endmodule

// File: rtl/frog_collide.sv
// Collision/goal judge. Each qualifying animation strobe snapshots the frog
// box and scans N_OBS obstacle slots through a registered-read index port,
// then reports death (overlap) or win (goal row reached).
// Optional lives/game-over tracking: define FROG_COLLIDE_LIVES_EN.
import frog_pkg::*;

module frog_collide #(
  parameter int N_OBS  = 8,
  parameter int IDX_W  = 3,
  parameter int GOAL_Y = 24,
  parameter int LIVES  = 3
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_ani_stb,
  input  logic               i_animate,
  input  logic [COORD_W-1:0] i_frog_x1,
  input  logic [COORD_W-1:0] i_frog_x2,
  input  logic [COORD_W-1:0] i_frog_y1,
  input  logic [COORD_W-1:0] i_frog_y2,
  output logic [IDX_W-1:0]   o_obs_idx,
  input  logic [COORD_W-1:0] i_obs_x1,
  input  logic [COORD_W-1:0] i_obs_x2,
  input  logic [COORD_W-1:0] i_obs_y1,
  input  logic [COORD_W-1:0] i_obs_y2,
  input  logic               i_obs_vld,
  output logic               o_dead,
  output logic               o_win,
  output logic [SCORE_W-1:0] o_score,
  output logic [1:0]         o_lives,
  output logic               o_game_over,
  output logic               o_busy
);

  localparam int CNT_W = IDX_W + 1;

  state_t           state, state_nxt;
  box_t             snap, obs;
  logic [CNT_W-1:0] step;
  logic             hit, overlap, stb, start, last;
  logic             dead, game_over;
  logic [1:0]       lives;

  assign stb   = i_ani_stb & i_animate;
  assign start = (state == IDLE) & stb & ~game_over;
  // step k compares the data returned for idx k-1; step N_OBS is the final compare
  assign last  = (step == CNT_W'(N_OBS));
  assign obs   = '{x1: i_obs_x1, x2: i_obs_x2, y1: i_obs_y1, y2: i_obs_y2};

  box_overlap u_overlap (
    .a   (snap),
    .b   (obs),
    .hit (overlap)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Snapshot, scan index, hit accumulation and result flags
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      snap      <= '0;
      step      <= '0;
      hit       <= 1'b0;
      dead      <= 1'b0;
      o_win     <= 1'b0;
      o_score   <= '0;
      o_obs_idx <= '0;
      o_busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            snap      <= '{x1: i_frog_x1, x2: i_frog_x2, y1: i_frog_y1, y2: i_frog_y2};
            hit       <= 1'b0;
            dead      <= 1'b0;
            o_win     <= 1'b0;
            o_obs_idx <= '0;
            step      <= '0;
            o_busy    <= 1'b1;
          end
        end
        SCAN: begin
          step <= step + 1'b1;
          if (step != '0) hit <= hit | (overlap & i_obs_vld);
          if (step < CNT_W'(N_OBS - 1)) o_obs_idx <= o_obs_idx + 1'b1;
          // busy drops with the final compare so it spans exactly the N_OBS+1 scan cycles
          if (last) o_busy <= 1'b0;
        end
        DONE: begin
          o_obs_idx <= '0;
          o_busy    <= 1'b0;
          if (hit) begin
            dead <= 1'b1;
          end else if (snap.y1 < COORD_W'(GOAL_Y)) begin
            o_win <= 1'b1;
            if (o_score != '1) o_score <= o_score + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FROG_COLLIDE_LIVES_EN
  // Lose a life on each death; game over is sticky until reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lives     <= 2'(LIVES);
      game_over <= 1'b0;
    end else if (state == DONE && hit) begin
      if (lives != 2'd0)  lives     <= lives - 2'd1;
      if (lives <= 2'd1)  game_over <= 1'b1;
    end
  end
`else
  assign lives     = 2'(LIVES);
  assign game_over = 1'b0;
`endif

  assign o_dead      = dead | game_over;
  assign o_lives     = lives;
  assign o_game_over = game_over;

endmodule

// File: tb/tb_frog_collide.sv
// Directed bench for frog_collide with a registered-read obstacle table.
import frog_pkg::*;

module tb_frog_collide;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               stb = 1'b0;
  logic               animate = 1'b1;
  box_t               frog;
  logic [2:0]         idx;
  box_t               obs_q;
  logic               vld_q;
  logic               dead, win, game_over, busy;
  logic [7:0]         score;
  logic [1:0]         lives;

  box_t mem [8];
  logic vld_mem [8];

  int checks   = 0;
  int failures = 0;
  int idx_log [16];
  int nlog;
  int exp_lives;
  int bc;
  logic dstart, wstart;

  always #5 clk = ~clk;

  frog_collide #(.N_OBS(8), .IDX_W(3), .GOAL_Y(24), .LIVES(3)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_ani_stb   (stb),
    .i_animate   (animate),
    .i_frog_x1   (frog.x1),
    .i_frog_x2   (frog.x2),
    .i_frog_y1   (frog.y1),
    .i_frog_y2   (frog.y2),
    .o_obs_idx   (idx),
    .i_obs_x1    (obs_q.x1),
    .i_obs_x2    (obs_q.x2),
    .i_obs_y1    (obs_q.y1),
    .i_obs_y2    (obs_q.y2),
    .i_obs_vld   (vld_q),
    .o_dead      (dead),
    .o_win       (win),
    .o_score     (score),
    .o_lives     (lives),
    .o_game_over (game_over),
    .o_busy      (busy)
  );

  // Obstacle table: data for idx appears the cycle after idx is presented
  always @(posedge clk) begin
    obs_q <= mem[idx];
    vld_q <= vld_mem[idx];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_slots();
    for (int i = 0; i < 8; i++) begin
      mem[i]     = '0;
      vld_mem[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge; pulses a strobe, logs idx while busy, returns after DONE applied
  task automatic frame(output int cnt);
    cnt  = 0;
    nlog = 0;
    stb  = 1'b1;
    @(negedge clk);
    stb    = 1'b0;
    dstart = dead;
    wstart = win;
    while (busy === 1'b1 && cnt < 50) begin
      if (nlog < 16) begin
        idx_log[nlog] = int'(idx);
        nlog++;
      end
      cnt++;
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic hit_frame();
    int c;
    frame(c);
`ifdef FROG_COLLIDE_LIVES_EN
    if (exp_lives > 0) exp_lives--;
`endif
  endtask

  initial begin
    frog = '{x1: 12'd309, x2: 12'd331, y1: 12'd458, y2: 12'd480};
    clear_slots();
    exp_lives = 3;
    do_reset();

    // Reset state
    check("rst_idx",   idx, 0);
    check("rst_dead",  dead, 0);
    check("rst_win",   win, 0);
    check("rst_busy",  busy, 0);
    check("rst_score", score, 0);
    check("rst_lives", lives, 3);
    check("rst_go",    game_over, 0);

    // 1: slot2 overlaps
    mem[2] = '{x1: 12'd300, x2: 12'd340, y1: 12'd450, y2: 12'd470};
    vld_mem[2] = 1'b1;
    hit_frame();
    check("t1_busy_len", bc_len(), 9);
    for (int k = 0; k < 9; k++) check($sformatf("t1_idx%0d", k), idx_log[k], (k < 7) ? k : 7);
    check("t1_dead",  dead, 1);
    check("t1_win",   win, 0);
    check("t1_lives", lives, exp_lives);
    check("t1_idx_back", idx, 0);

    // 2: edge touch in x is not a hit; dead clears at the strobe
    clear_slots();
    mem[0] = '{x1: 12'd331, x2: 12'd340, y1: 12'd450, y2: 12'd470};
    vld_mem[0] = 1'b1;
    frame(bc);
    check("t2_dead_clr", dstart, 0);
    check("t2_dead",     dead, 0);
    check("t2_win",      win, 0);
    check("t2_lives",    lives, exp_lives);

    // 3: goal row, no valid slots
    clear_slots();
    frog.y1 = 12'd10;
    frog.y2 = 12'd32;
    frame(bc);
    check("t3_win",   win, 1);
    check("t3_dead",  dead, 0);
    check("t3_score", score, 1);

    // 4: goal row but slot5 overlaps: death wins
    mem[5] = '{x1: 12'd300, x2: 12'd340, y1: 12'd0, y2: 12'd40};
    vld_mem[5] = 1'b1;
    hit_frame();
    check("t4_win_clr", wstart, 0);
    check("t4_dead",    dead, 1);
    check("t4_win",     win, 0);
    check("t4_score",   score, 1);
    check("t4_lives",   lives, exp_lives);

    // Animate low: strobe ignored
    animate = 1'b0;
    stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
    check("anim_off_busy", busy, 0);
    animate = 1'b1;

    // 3b: score saturation (fresh reset restores lives)
    do_reset();
    exp_lives = 3;
    clear_slots();
    for (int n = 0; n < 254; n++) frame(bc);
    check("sat_254", score, 254);
    frame(bc);
    check("sat_255", score, 255);
    frame(bc);
    check("sat_hold", score, 255);
    check("sat_win",  win, 1);

    // 5: three hit frames
    frog = '{x1: 12'd309, x2: 12'd331, y1: 12'd458, y2: 12'd480};
    mem[2] = '{x1: 12'd300, x2: 12'd340, y1: 12'd450, y2: 12'd470};
    vld_mem[2] = 1'b1;
    hit_frame();
    check("t5_lives_a", lives, exp_lives);
    hit_frame();
    check("t5_lives_b", lives, exp_lives);
    hit_frame();
    check("t5_lives_c", lives, exp_lives);
    check("t5_dead",    dead, 1);
    stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
`ifdef FROG_COLLIDE_LIVES_EN
    check("t5_go",        game_over, 1);
    check("t5_busy_stay", busy, 0);
    check("t5_dead_stuck", dead, 1);
    repeat (12) @(negedge clk);
    check("t5_dead_later", dead, 1);
    do_reset();
    check("t5_rst_lives", lives, 3);
    check("t5_rst_go",    game_over, 0);
`else
    check("t5_go",      game_over, 0);
    check("t5_busy_go", busy, 1);
    repeat (12) @(negedge clk);
    do_reset();
`endif

    // 6: reset mid-scan at idx 4
    frame_start();
    bc = 0;
    while (idx != 3'd4 && bc < 20) begin
      bc++;
      @(negedge clk);
    end
    check("t6_reach4", idx, 4);
    rst = 1'b1;
    @(negedge clk);
    check("t6_busy", busy, 0);
    check("t6_idx",  idx, 0);
    check("t6_dead", dead, 0);
    rst = 1'b0;
    @(negedge clk);

    // 6b: strobe while busy is dropped
    stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
    bc = 0;
    while (busy === 1'b1 && bc < 50) begin
      stb = (bc == 3);
      bc++;
      @(negedge clk);
    end
    stb = 1'b0;
    check("t6_len", bc, 9);
    repeat (3) @(negedge clk);
    check("t6_no_queue", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic int bc_len();
    return nlog;
  endfunction

  task automatic frame_start();
    stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "timeout");
  end

endmodule
